// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use bubbles, branch/jump flushes,
// data-memory wait states with a sticky timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int              WCW      = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0]  WAIT_LIM = WCW'(WAIT_MAX);
    localparam logic [5:0]      OP_R     = 6'b000000;
    localparam logic [5:0]      OP_J     = 6'b000010;
    localparam logic [5:0]      OP_BEQ   = 6'b000100;
    localparam logic [5:0]      OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b11
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           rs_used;
    logic           rt_used;
    logic           lu;
    logic           miss;
    logic           hold;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        rs_used = (id_opcode != OP_J);
        rt_used = (id_opcode == OP_R) || (id_opcode == OP_BEQ) || (id_opcode == OP_SW);
        lu      = ex_mem_read && (ex_rt != 5'd0) &&
                  (((ex_rt == id_rs) && rs_used) || ((ex_rt == id_rt) && rt_used));
        miss    = mem_req && !mem_ready;

        case (state)
            RUN:      hold = miss;
            MEM_WAIT: hold = !mem_ready;
            default:  hold = 1'b1;
        endcase

        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;

        // Reset forces a clean front end; after that, hold beats flush beats bubble beats jump
        if (!res) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end

        mem_timeout = (state == TIMEOUT);
        ctrl_state  = state;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            // Squashed (flushed) cycles are not stalls; everything else that freezes the PC is
            if (!pc_write && !ifid_flush)
                stall_cycles <= sat_inc(stall_cycles);

            case (state)
                RUN: begin
                    if (miss) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready)
                        state <= RUN;
                    else if (wait_cnt == WAIT_LIM)
                        state <= TIMEOUT;
                    else
                        wait_cnt <= wait_cnt + WCW'(1);
                end
                TIMEOUT: state <= TIMEOUT;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage 32-bit RISC core. It sits beside the main `control` decoder and drives the PC, IF/ID and ID/EX write-enable, flush and bubble controls. It resolves load-use hazards, taken-branch and jump flushes, and data-memory wait states. It also raises a sticky timeout when data memory never answers and keeps a saturating stall-cycle counter.

## Interface
- `WAIT_MAX`, default 8: maximum counted MEM_WAIT cycles before timeout. Must be ≥1.
- `CNT_W`, default 16: width of the stall-cycle counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `res` in 1: reset, asynchronous, active-low.
- `id_opcode` in 6: opcode of the instruction in ID.
- `id_rs` in 5: source register of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `ex_mem_read` in 1: MemRead of the instruction in EX (a load).
- `ex_rt` in 5: destination of the instruction in EX.
- `ex_branch_taken` in 1: beq in EX resolved as taken.
- `id_jump` in 1: Jump decoded in ID.
- `mem_req` in 1: MEM stage is performing a read or write this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID register enable.
- `ifid_flush` out 1: load NOP into IF/ID.
- `idex_bubble` out 1: zero all control fields entering ID/EX.
- `pipe_hold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `mem_timeout` out 1: sticky memory-timeout flag.
- `ctrl_state` out 2: FSM state: RUN=00, MEM_WAIT=01, TIMEOUT=11.
- `stall_cycles` out CNT_W: saturating stall counter.

## Operation
- ID source use:
  - rs is used by every opcode except j (000010).
  - rt is used only by R-type (000000), beq (000100) and sw (101011).
- Load-use hazard (`lu`) = `ex_mem_read` && `ex_rt`≠0 && (`ex_rt`==`id_rs` with rs used, or `ex_rt`==`id_rt` with rt used).
- Memory miss (`miss`) = `mem_req` && !`mem_ready`.
- Outputs are combinational from state and inputs. Default is `pc_write`=1, `ifid_write`=1, all others 0.
- RUN, priority highest first:
  1. `miss`: `pc_write`=0, `ifid_write`=0, `pipe_hold`=1. Next state MEM_WAIT, `wait_cnt`←1.
  2. `ex_branch_taken`: `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1. Stay RUN.
  3. `lu`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Stay RUN; this is a one-cycle bubble.
  4. `id_jump`: `ifid_flush`=1, `pc_write`=1. Stay RUN.
- MEM_WAIT:
  - While !`mem_ready`: outputs as RUN case 1; `wait_cnt`++.
  - If `wait_cnt`==`WAIT_MAX` and !`mem_ready`: next state TIMEOUT.
  - If `mem_ready`=1: outputs evaluated exactly as RUN cases 2-4 (miss term false), next state RUN.
- TIMEOUT: `pc_write`=0, `ifid_write`=0, `pipe_hold`=1, `mem_timeout`=1. All inputs are ignored, including `mem_ready`. The only exit is reset.
- `wait_cnt` width is $clog2(`WAIT_MAX`+1). It is internal and meaningful only in MEM_WAIT.
- `stall_cycles`:
  - Increments on each edge where `pc_write`=0 && `ifid_flush`=0. This covers load-use, miss and TIMEOUT cycles.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Flush cycles are not counted.

## Timing
- Reset (`res`=0, asynchronous):
  - State: `ctrl_state`=00, `wait_cnt`=0, `stall_cycles`=0, `mem_timeout`=0.
  - While `res`=0: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1, `pipe_hold`=0.
  - First normal cycle is the first edge after deassertion.
- Reset mid-MEM_WAIT or in TIMEOUT returns immediately to RUN; the memory transaction is abandoned.
- Hazard response has zero-cycle latency: it is combinational in the cycle the condition is present.
- State and counters update at the next rising edge.
- Miss plus branch taken: the miss wins. EX is frozen, so the branch re-presents and flushes in the release cycle.
- Branch plus load-use: the branch wins. The ID instruction is squashed, so no stall is counted.
- Timeout sequence: a miss in RUN at cycle 0 is followed by MEM_WAIT for cycles 1..`WAIT_MAX`. TIMEOUT and `mem_timeout`=1 start at cycle `WAIT_MAX`+1.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=5, `id_opcode`=000000, `id_rt`=5 → one cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, then `stall_cycles`=1.
  - Repeat with `ex_rt`=0, or with `id_opcode`=100011 (rt=5, rs=3) → no stall.
- Branch taken in the same cycle as a load-use → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1; `stall_cycles` unchanged.
- `mem_req`=1 with `mem_ready`=0 for cycles 0-2 and 1 at cycle 3 (`WAIT_MAX`=8):
  - `pipe_hold`=1 and `pc_write`=0 in cycles 0-2, with `ctrl_state`=01 in cycles 1-2.
  - Cycle 3 releases; `ctrl_state`=00 after that edge; `stall_cycles`=3.
- `mem_ready` stuck at 0 (`WAIT_MAX`=8) → `ctrl_state`=11 and `mem_timeout`=1 from cycle 9. These hold after `mem_ready` later rises, and clear only on `res`=0.
- Reset asserted while in MEM_WAIT at wait_cnt=4 → immediately `ctrl_state`=00, `stall_cycles`=0, `idex_bubble`=1, `ifid_flush`=1.
- `CNT_W`=4 with 20 consecutive stall cycles → `stall_cycles`=15, held.
